// File: rtl/cd_pkg.sv
// Shared types and widths for the compression engine host-side master.
package cd_pkg;

    localparam int CD_DATA_W = 80;
    localparam int CD_CODE_W = 8;

    typedef enum logic [1:0] {
        CD_NOP        = 2'b00,
        CD_COMPRESS   = 2'b01,
        CD_DECOMPRESS = 2'b10,
        CD_RSVD       = 2'b11
    } cd_cmd_e;

    typedef enum logic [1:0] {
        CD_NONE      = 2'b00,
        CD_COMP_OK   = 2'b01,
        CD_DECOMP_OK = 2'b10,
        CD_ERROR     = 2'b11
    } cd_rsp_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_WAIT  = 2'b10,
        ST_HOLD  = 2'b11
    } cd_master_state_e;

    function automatic logic [15:0] cd_sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/cd_wait_timer.sv
// Response wait timer: counts WAIT samples up from zero and flags the last one.
module cd_wait_timer #(
    parameter int TIMEOUT = 64,
    localparam int CNT_W  = $clog2(TIMEOUT + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign expired_o = (cnt_q == CNT_W'(TIMEOUT - 1));

    // Holds at the terminal value so the counter can never wrap.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && !expired_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/cd_cmd_master.sv
// Host-side initiator for the compression engine: one outstanding request at a time.
// Optional statistics counters are enabled with CD_CMD_MASTER_STATS_EN.
//
// state    | meaning
// ST_IDLE  | ready for a request
// ST_ISSUE | command driven to the engine for one cycle
// ST_WAIT  | sampling response until nonzero or timeout
// ST_HOLD  | result presented until rsp_ready
module cd_cmd_master
    import cd_pkg::*;
#(
    parameter int DATA_W  = CD_DATA_W,
    parameter int CODE_W  = CD_CODE_W,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_cmd,
    input  logic [DATA_W-1:0] req_data,
    input  logic [CODE_W-1:0] req_code,
    output logic [1:0]        command,
    output logic [DATA_W-1:0] data_in,
    output logic [CODE_W-1:0] compressed_in,
    input  logic [CODE_W-1:0] compressed_out,
    input  logic [DATA_W-1:0] decompressed_out,
    input  logic [1:0]        response,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [1:0]        rsp_status,
    output logic              rsp_timeout,
    output logic [CODE_W-1:0] rsp_code,
    output logic [DATA_W-1:0] rsp_data
`ifdef CD_CMD_MASTER_STATS_EN
    ,
    output logic [15:0]       stat_issued,
    output logic [15:0]       stat_errors,
    output logic [15:0]       stat_spurious
`endif
);

    cd_master_state_e  state_q;
    logic              req_ready_q;
    logic [1:0]        command_q;
    logic [DATA_W-1:0] data_in_q;
    logic [CODE_W-1:0] code_in_q;
    logic              rsp_valid_q;
    logic [1:0]        rsp_status_q;
    logic              rsp_timeout_q;
    logic [CODE_W-1:0] rsp_code_q;
    logic [DATA_W-1:0] rsp_data_q;
    logic              tmr_expired;

    cd_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk       (clk),
        .reset     (reset),
        .clear_i   (state_q == ST_ISSUE),
        .enable_i  (state_q == ST_WAIT),
        .expired_o (tmr_expired)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            req_ready_q   <= 1'b1;
            command_q     <= CD_NOP;
            data_in_q     <= '0;
            code_in_q     <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_status_q  <= CD_NONE;
            rsp_timeout_q <= 1'b0;
            rsp_code_q    <= '0;
            rsp_data_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        case (cd_cmd_e'(req_cmd))
                            CD_COMPRESS, CD_DECOMPRESS: begin
                                state_q     <= ST_ISSUE;
                                req_ready_q <= 1'b0;
                                command_q   <= req_cmd;
                                data_in_q   <= req_data;
                                code_in_q   <= req_code;
                            end
                            // Reserved command is answered locally; the engine never sees it.
                            CD_RSVD: begin
                                state_q       <= ST_HOLD;
                                req_ready_q   <= 1'b0;
                                rsp_valid_q   <= 1'b1;
                                rsp_status_q  <= CD_ERROR;
                                rsp_timeout_q <= 1'b0;
                            end
                            default: ;
                        endcase
                    end
                end
                ST_ISSUE: begin
                    command_q <= CD_NOP;
                    state_q   <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (response != CD_NONE) begin
                        state_q       <= ST_HOLD;
                        rsp_valid_q   <= 1'b1;
                        rsp_status_q  <= response;
                        rsp_timeout_q <= 1'b0;
                        rsp_code_q    <= compressed_out;
                        rsp_data_q    <= decompressed_out;
                    end else if (tmr_expired) begin
                        state_q       <= ST_HOLD;
                        rsp_valid_q   <= 1'b1;
                        rsp_status_q  <= CD_ERROR;
                        rsp_timeout_q <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (rsp_ready) begin
                        state_q     <= ST_IDLE;
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign req_ready     = req_ready_q;
    assign command       = command_q;
    assign data_in       = data_in_q;
    assign compressed_in = code_in_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_status    = rsp_status_q;
    assign rsp_timeout   = rsp_timeout_q;
    assign rsp_code      = rsp_code_q;
    assign rsp_data      = rsp_data_q;

`ifdef CD_CMD_MASTER_STATS_EN
    logic [15:0] stat_issued_q;
    logic [15:0] stat_errors_q;
    logic [15:0] stat_spurious_q;
    logic        err_entry;

    assign err_entry = ((state_q == ST_IDLE) && req_valid && (req_cmd == CD_RSVD)) ||
                       ((state_q == ST_WAIT) && ((response == CD_ERROR) ||
                                                 ((response == CD_NONE) && tmr_expired)));

    always_ff @(posedge clk) begin
        if (!reset) begin
            stat_issued_q   <= '0;
            stat_errors_q   <= '0;
            stat_spurious_q <= '0;
        end else begin
            if (state_q == ST_ISSUE) begin
                stat_issued_q <= cd_sat_inc(stat_issued_q);
            end
            if (err_entry) begin
                stat_errors_q <= cd_sat_inc(stat_errors_q);
            end
            if ((state_q != ST_WAIT) && (response != CD_NONE)) begin
                stat_spurious_q <= cd_sat_inc(stat_spurious_q);
            end
        end
    end

    assign stat_issued   = stat_issued_q;
    assign stat_errors   = stat_errors_q;
    assign stat_spurious = stat_spurious_q;
`endif

endmodule

// File: tb/tb_cd_cmd_master.sv
// Bench for cd_cmd_master: directed scenarios plus randomized traffic against a transaction-level model.
module tb_cd_cmd_master;

    localparam int TO = 4;
    localparam logic [79:0] WORD = 80'h8000_0000_3500_0260_000B;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_cmd = 2'b00;
    logic [79:0] req_data = '0;
    logic [7:0]  req_code = '0;
    logic [1:0]  command;
    logic [79:0] data_in;
    logic [7:0]  compressed_in;
    logic [7:0]  compressed_out = '0;
    logic [79:0] decompressed_out = '0;
    logic [1:0]  response = 2'b00;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [1:0]  rsp_status;
    logic        rsp_timeout;
    logic [7:0]  rsp_code;
    logic [79:0] rsp_data;
`ifdef CD_CMD_MASTER_STATS_EN
    logic [15:0] stat_issued;
    logic [15:0] stat_errors;
    logic [15:0] stat_spurious;
`endif

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    cd_cmd_master #(
        .DATA_W  (80),
        .CODE_W  (8),
        .TIMEOUT (TO)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_cmd          (req_cmd),
        .req_data         (req_data),
        .req_code         (req_code),
        .command          (command),
        .data_in          (data_in),
        .compressed_in    (compressed_in),
        .compressed_out   (compressed_out),
        .decompressed_out (decompressed_out),
        .response         (response),
        .rsp_valid        (rsp_valid),
        .rsp_ready        (rsp_ready),
        .rsp_status       (rsp_status),
        .rsp_timeout      (rsp_timeout),
        .rsp_code         (rsp_code),
        .rsp_data         (rsp_data)
`ifdef CD_CMD_MASTER_STATS_EN
        ,
        .stat_issued      (stat_issued),
        .stat_errors      (stat_errors),
        .stat_spurious    (stat_spurious)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [79:0] rand80();
        logic [95:0] t;
        t = {$urandom(), $urandom(), $urandom()};
        return t[79:0];
    endfunction

    // Transaction model: one outstanding request, aged in clock edges since acceptance.
    // Age 1 is the command cycle; every later edge is a response sample numbered age-1.
    bit          m_busy = 0;
    bit          m_done = 0;
    int          m_age = 0;
    int          m_k;
    logic [1:0]  m_cmd = '0;
    logic [79:0] m_din = '0;
    logic [7:0]  m_cin = '0;
    logic [1:0]  m_status = '0;
    logic        m_timeout = 0;
    logic [7:0]  m_rcode = '0;
    logic [79:0] m_rdata = '0;
    logic [15:0] m_issued = '0;
    logic [15:0] m_errs = '0;
    logic [15:0] m_spur = '0;

    function automatic logic [15:0] sat(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always @(posedge clk) begin
        if (!reset) begin
            m_busy = 0; m_done = 0; m_age = 0; m_cmd = '0;
            m_din = '0; m_cin = '0; m_status = '0; m_timeout = 0;
            m_rcode = '0; m_rdata = '0;
            m_issued = '0; m_errs = '0; m_spur = '0;
        end else begin
            if (response != 2'b00 && !(m_busy && !m_done && m_age >= 2)) m_spur = sat(m_spur);
            if (m_busy && m_done) begin
                if (rsp_ready) begin m_busy = 0; m_done = 0; end
            end else if (m_busy) begin
                if (m_age == 1) begin
                    m_issued = sat(m_issued);
                    m_age = 2;
                end else begin
                    m_k = m_age - 1;
                    if (response != 2'b00) begin
                        m_done = 1; m_status = response; m_timeout = 0;
                        m_rcode = compressed_out; m_rdata = decompressed_out;
                        if (response == 2'b11) m_errs = sat(m_errs);
                    end else if (m_k == TO) begin
                        m_done = 1; m_status = 2'b11; m_timeout = 1;
                        m_errs = sat(m_errs);
                    end else begin
                        m_age++;
                    end
                end
            end else if (req_valid) begin
                if (req_cmd == 2'b01 || req_cmd == 2'b10) begin
                    m_busy = 1; m_done = 0; m_age = 1; m_cmd = req_cmd;
                    m_din = req_data; m_cin = req_code;
                end else if (req_cmd == 2'b11) begin
                    m_busy = 1; m_done = 1; m_status = 2'b11; m_timeout = 0;
                    m_errs = sat(m_errs);
                end
            end
        end
    end

    logic [1:0] exp_command;
    assign exp_command = (m_busy && !m_done && m_age == 1) ? m_cmd : 2'b00;

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("req_ready", 80'(req_ready), 80'(!m_busy));
            chk("command", 80'(command), 80'(exp_command));
            chk("data_in", data_in, m_din);
            chk("compressed_in", 80'(compressed_in), 80'(m_cin));
            chk("rsp_valid", 80'(rsp_valid), 80'(m_done));
            chk("rsp_code", 80'(rsp_code), 80'(m_rcode));
            chk("rsp_data", rsp_data, m_rdata);
            if (m_done) begin
                chk("rsp_status", 80'(rsp_status), 80'(m_status));
                chk("rsp_timeout", 80'(rsp_timeout), 80'(m_timeout));
            end
`ifdef CD_CMD_MASTER_STATS_EN
            chk("stat_issued", 80'(stat_issued), 80'(m_issued));
            chk("stat_errors", 80'(stat_errors), 80'(m_errs));
            chk("stat_spurious", 80'(stat_spurious), 80'(m_spur));
`endif
        end
    end

    // Issue one request; k>0 answers on WAIT sample k, k==0 lets it time out.
    task automatic run_req(input logic [1:0] cmd, input int k, input logic [1:0] rsp);
        int n;
        @(negedge clk);
        req_valid = 1'b1; req_cmd = cmd; req_data = rand80(); req_code = 8'($urandom());
        @(negedge clk);
        req_valid = 1'b0;
        if (k > 0) begin
            repeat (k) @(negedge clk);
            response = rsp; compressed_out = 8'($urandom()); decompressed_out = rand80();
            @(negedge clk);
            response = 2'b00;
        end
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("handshake_bound", 80'(rsp_valid), 80'(1));
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        reset = 1'b1;
        chk("rst_req_ready", 80'(req_ready), 80'(1));
        chk("rst_command", 80'(command), 80'(0));
        chk("rst_rsp_valid", 80'(rsp_valid), 80'(0));
        chk("rst_rsp_status", 80'(rsp_status), 80'(0));
        chk("rst_rsp_code", 80'(rsp_code), 80'(0));
        chk("rst_data_in", data_in, 80'(0));
        cmp_en = 1'b1;

        // Compress, answered on the third WAIT sample.
        @(negedge clk);
        req_valid = 1'b1; req_cmd = 2'b01; req_data = WORD; req_code = 8'h00;
        @(negedge clk);
        req_valid = 1'b0;
        chk("cmp_cmd", 80'(command), 80'(1));
        chk("cmp_model_cmd", 80'(exp_command), 80'(1));
        chk("cmp_req_ready", 80'(req_ready), 80'(0));
        chk("cmp_data_in", data_in, WORD);
        @(negedge clk);
        chk("cmp_cmd_once", 80'(command), 80'(0));
        repeat (2) @(negedge clk);
        response = 2'b01; compressed_out = 8'hF0;
        @(negedge clk);
        response = 2'b00;
        chk("cmp_valid", 80'(rsp_valid), 80'(1));
        chk("cmp_status", 80'(rsp_status), 80'(1));
        chk("cmp_code", 80'(rsp_code), 80'(8'hF0));
        chk("cmp_timeout", 80'(rsp_timeout), 80'(0));
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("cmp_release", 80'(rsp_valid), 80'(0));

        // Decompress, answered on the first WAIT sample.
        @(negedge clk);
        req_valid = 1'b1; req_cmd = 2'b10; req_code = 8'hF0;
        @(negedge clk);
        req_valid = 1'b0;
        chk("dec_cmd", 80'(command), 80'(2));
        chk("dec_code_in", 80'(compressed_in), 80'(8'hF0));
        @(negedge clk);
        response = 2'b10; decompressed_out = WORD;
        @(negedge clk);
        response = 2'b00; decompressed_out = '0;
        chk("dec_status", 80'(rsp_status), 80'(2));
        chk("dec_data", rsp_data, WORD);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;

        // Timeout after exactly TO samples; previous captures must survive.
        @(negedge clk);
        req_valid = 1'b1; req_cmd = 2'b01; req_data = rand80();
        @(negedge clk);
        req_valid = 1'b0;
        repeat (TO) @(negedge clk);
        chk("to_not_early", 80'(rsp_valid), 80'(0));
        @(negedge clk);
        chk("to_valid", 80'(rsp_valid), 80'(1));
        chk("to_status", 80'(rsp_status), 80'(3));
        chk("to_flag", 80'(rsp_timeout), 80'(1));
        chk("to_code_kept", 80'(rsp_code), 80'(8'hF0));
        chk("to_data_kept", rsp_data, WORD);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;

        // Response on the last sample beats the timeout.
        @(negedge clk);
        req_valid = 1'b1; req_cmd = 2'b01; req_data = rand80();
        @(negedge clk);
        req_valid = 1'b0;
        repeat (TO) @(negedge clk);
        response = 2'b01; compressed_out = 8'h3C;
        @(negedge clk);
        response = 2'b00;
        chk("late_status", 80'(rsp_status), 80'(1));
        chk("late_flag", 80'(rsp_timeout), 80'(0));
        chk("late_code", 80'(rsp_code), 80'(8'h3C));
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;

        // Reserved command with backpressure.
        @(negedge clk);
        req_valid = 1'b1; req_cmd = 2'b11;
        @(negedge clk);
        req_valid = 1'b0;
        chk("rsv_command", 80'(command), 80'(0));
        chk("rsv_status", 80'(rsp_status), 80'(3));
        chk("rsv_timeout", 80'(rsp_timeout), 80'(0));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", 80'(rsp_valid), 80'(1));
            chk("bp_status", 80'(rsp_status), 80'(3));
            chk("bp_code", 80'(rsp_code), 80'(8'h3C));
            chk("bp_req_ready", 80'(req_ready), 80'(0));
            chk("bp_command", 80'(command), 80'(0));
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;

        // Reset while waiting, then a late response in IDLE.
        @(negedge clk);
        req_valid = 1'b1; req_cmd = 2'b01; req_data = rand80();
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk("mrst_command", 80'(command), 80'(0));
        chk("mrst_valid", 80'(rsp_valid), 80'(0));
        chk("mrst_req_ready", 80'(req_ready), 80'(1));
        chk("mrst_data_in", data_in, 80'(0));
        response = 2'b01;
        @(negedge clk);
        response = 2'b00;
        chk("mrst_ignored", 80'(rsp_valid), 80'(0));
        chk("mrst_still_ready", 80'(req_ready), 80'(1));

        run_req(2'b01, 2, 2'b01);
        run_req(2'b01, 0, 2'b00);
        run_req(2'b01, 1, 2'b01);
        @(negedge clk);
`ifdef CD_CMD_MASTER_STATS_EN
        chk("st_issued", 80'(stat_issued), 80'(3));
        chk("st_errors", 80'(stat_errors), 80'(1));
        chk("st_spurious", 80'(stat_spurious), 80'(1));
`endif

        // Randomized traffic; the model checks every cycle.
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            req_valid        = ($urandom_range(0, 1) == 0);
            req_cmd          = 2'($urandom_range(0, 3));
            req_data         = rand80();
            req_code         = 8'($urandom());
            response         = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            compressed_out   = 8'($urandom());
            decompressed_out = rand80();
            rsp_ready        = ($urandom_range(0, 2) == 0);
            reset            = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
        end
        @(negedge clk);
        reset = 1'b1; req_valid = 1'b0; response = 2'b00;
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
